// File: rtl/knn_result_streamer.sv
// Purpose: buffers {name,value} k-NN results and streams each one as two AXIS beats (name, then value); tlast closes every K-th result.
// Latency: a result written into an empty buffer shows its name beat one cycle later; streams with no bubbles while results are queued.
// Backpressure: a stalled beat holds steady and results queue in the FIFO; writes into a full FIFO are dropped and set sticky overflow.
module knn_result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 1,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_wr_en,
  input  logic [31:0]           in_name,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic                  frame_done
);

  // A one-entry buffer still needs a 1-bit pointer; the wrap logic keeps it at 0.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    LAST_IDX = 8'(K - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NAME  = 2'd1;
  localparam logic [1:0] S_VALUE = 2'd2;

  logic [31:0]           r_name_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_value_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_entry_cnt;
  logic [1:0]            r_state;
  logic                  r_tvalid;
  logic [31:0]           r_tdata;
  logic                  r_tlast;
  logic                  r_overflow;
  logic                  r_frame_done;

  logic                  w_full;
  logic                  w_handshake;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_more;
  logic [AW-1:0]         w_wr_next;
  logic [AW-1:0]         w_rd_next;
  logic [31:0]           w_next_name;
  logic [31:0]           w_head_value;

  // Fullness uses the occupancy before any same-cycle pop, so a write into a
  // full buffer is dropped even when the head leaves on the same edge.
  assign w_full      = (r_count == FULL_CNT);
  assign w_handshake = r_tvalid & m_axis_tready;
  assign w_push      = in_wr_en & ~w_full & ~clear;
  assign w_pop       = (r_state == S_VALUE) & w_handshake & ~clear;
  assign w_wr_next   = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
  assign w_rd_next   = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);

  // An entry remains after the pop if one was queued behind the head or one
  // is being written right now; the latter is forwarded straight from the
  // input so the next name beat follows without a bubble.
  assign w_more      = (r_count > CW'(1)) | w_push;
  assign w_next_name = (r_count > CW'(1)) ? r_name_mem[w_rd_next] : in_name;

  // Zero-extend the head distance to the 32-bit stream width.
  always_comb begin
    w_head_value = '0;
    w_head_value[DATA_WIDTH-1:0] = r_value_mem[r_rd_ptr];
  end

  // Result storage; occupancy gates every read, so contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_name_mem[r_wr_ptr]  <= in_name;
      r_value_mem[r_wr_ptr] <= in_value;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_next;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag, only cleared by clear or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (in_wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Output FSM: every stream output is a register loaded on the transition into its beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_entry_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_entry_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state  <= S_NAME;
            r_tvalid <= 1'b1;
            r_tdata  <= r_name_mem[r_rd_ptr];
            r_tlast  <= 1'b0;
          end
        end
        S_NAME: begin
          if (w_handshake) begin
            r_state <= S_VALUE;
            r_tdata <= w_head_value;
            r_tlast <= (r_entry_cnt == LAST_IDX);
          end
        end
        S_VALUE: begin
          if (w_handshake) begin
            r_frame_done <= r_tlast;
            r_entry_cnt  <= r_tlast ? 8'd0 : r_entry_cnt + 8'd1;
            r_tlast      <= 1'b0;
            if (w_more) begin
              r_state <= S_NAME;
              r_tdata <= w_next_name;
            end else begin
              r_state  <= S_IDLE;
              r_tvalid <= 1'b0;
              r_tdata  <= '0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tvalid <= 1'b0;
          r_tdata  <= '0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign overflow      = r_overflow;
  assign frame_done    = r_frame_done;

endmodule
